// File: rtl/cmd_seq_ctrl.sv
// cmd_seq_ctrl: fetches CMD_WORDS-beat commands, starts one of NUM_ENG engines and loops for cmd_size commands.
// cmd_ready is high only in FETCH, one cycle after the last eng_done. Define CMD_SEQ_PERF_CNT_EN to enable perf_cycles.
module cmd_seq_ctrl #(
  parameter int CMD_WORDS = 8,
  parameter int PARA      = 16,
  parameter int NUM_ENG   = 3,
  parameter int CNT_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_en,
  input  logic               cmd_valid,
  input  logic [31:0]        cmd_data,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_size,
  output logic [NUM_ENG-1:0] eng_start,
  input  logic [NUM_ENG-1:0] eng_done,
  output logic [2:0]         op_type,
  output logic               padding,
  output logic [3:0]         stride,
  output logic [15:0]        op_num,
  output logic [7:0]         kernel_size,
  output logic [7:0]         i_side_size,
  output logic [7:0]         o_side_size,
  output logic [15:0]        i_surf_size,
  output logic [15:0]        o_surf_size,
  output logic [15:0]        i_channel_size,
  output logic [15:0]        o_channel_size,
  output logic [31:0]        weight_start_addr,
  output logic [31:0]        data_start_addr,
  output logic [31:0]        result_start_addr,
  output logic               engine_reset,
  output logic               busy,
  output logic               err,
  output logic               irq,
  input  logic               irq_clr,
  output logic [31:0]        perf_cycles
);

  localparam int WI_W = $clog2(CMD_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RUN, S_DONE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [WI_W-1:0]    word_idx_q, word_idx_d;
  logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [15:0]        surf_cnt_q, surf_cnt_d;
  logic [16:0]        chan_cnt_q, chan_cnt_d;
  logic [NUM_ENG-1:0] eng_start_q, eng_start_d;

  logic [2:0]  op_type_q;
  logic        padding_q;
  logic [3:0]  stride_q;
  logic [15:0] op_num_q;
  logic [7:0]  kernel_q, i_side_q, o_side_q;
  logic [15:0] i_surf_q, o_surf_q, i_chan_q, o_chan_q;
  logic [31:0] waddr_q, daddr_q, raddr_q;

  logic        beat, last_beat, done_hit, surf_wrap, op_cmpl, eng_ok;
  logic [2:0]  eng_idx;
  logic [16:0] chan_nxt;

  assign beat      = (state_q == S_FETCH) && cmd_valid;
  assign last_beat = beat && (word_idx_q == WI_W'(CMD_WORDS - 1));
  // Only the engine we started may advance the pixel counters.
  assign done_hit  = (state_q == S_RUN) && (|(eng_done & eng_start_q));
  assign surf_wrap = (({1'b0, surf_cnt_q} + 17'd1) == {1'b0, o_surf_q});
  assign chan_nxt  = chan_cnt_q + 17'(PARA);
  assign op_cmpl   = done_hit && surf_wrap && (chan_nxt >= {1'b0, o_chan_q});

  always_comb begin
    eng_idx = 3'd0;
    case (op_type_q)
      3'd4:    eng_idx = 3'd1;
      3'd5:    eng_idx = 3'd2;
      3'd6:    eng_idx = 3'd3;
      3'd7:    eng_idx = 3'd4;
      default: eng_idx = 3'd0;
    endcase
  end

  assign eng_ok = (op_type_q != 3'd0) && ({29'd0, eng_idx} < 32'(NUM_ENG));

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    cmd_cnt_d   = cmd_cnt_q;
    surf_cnt_d  = surf_cnt_q;
    chan_cnt_d  = chan_cnt_q;
    eng_start_d = eng_start_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_en) begin
          cmd_cnt_d  = '0;
          word_idx_d = '0;
          state_d    = (cmd_size == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (last_beat) begin
          word_idx_d = '0;
          state_d    = S_ISSUE;
        end else if (beat) begin
          word_idx_d = word_idx_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (!eng_ok || (o_surf_q == 16'd0) || (o_chan_q == 16'd0)) begin
          state_d = S_ERR;
        end else begin
          eng_start_d = NUM_ENG'(1) << eng_idx;
          surf_cnt_d  = '0;
          chan_cnt_d  = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (done_hit) begin
          if (surf_wrap) begin
            surf_cnt_d = '0;
            chan_cnt_d = chan_nxt;
          end else begin
            surf_cnt_d = surf_cnt_q + 16'd1;
          end
          if (op_cmpl) begin
            eng_start_d = '0;
            cmd_cnt_d   = cmd_cnt_q + 1'b1;
            state_d     = (({1'b0, cmd_cnt_q} + 1'b1) == {1'b0, cmd_size}) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (irq_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      cmd_cnt_q   <= '0;
      surf_cnt_q  <= '0;
      chan_cnt_q  <= '0;
      eng_start_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      cmd_cnt_q   <= cmd_cnt_d;
      surf_cnt_q  <= surf_cnt_d;
      chan_cnt_q  <= chan_cnt_d;
      eng_start_q <= eng_start_d;
    end
  end

  // Words past index 7 are accepted but carry nothing we decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_type_q <= '0;
      padding_q <= 1'b0;
      stride_q  <= '0;
      op_num_q  <= '0;
      i_chan_q  <= '0;
      o_chan_q  <= '0;
      i_side_q  <= '0;
      o_side_q  <= '0;
      kernel_q  <= '0;
      i_surf_q  <= '0;
      o_surf_q  <= '0;
      waddr_q   <= '0;
      daddr_q   <= '0;
      raddr_q   <= '0;
    end else if (beat) begin
      case (word_idx_q)
        WI_W'(0): begin
          op_type_q <= cmd_data[2:0];
          padding_q <= cmd_data[4];
          stride_q  <= cmd_data[11:8];
          op_num_q  <= cmd_data[31:16];
        end
        WI_W'(2): begin
          i_chan_q <= cmd_data[15:0];
          o_chan_q <= cmd_data[31:16];
        end
        WI_W'(3): begin
          i_side_q <= cmd_data[7:0];
          o_side_q <= cmd_data[15:8];
          kernel_q <= cmd_data[23:16];
        end
        WI_W'(4): begin
          i_surf_q <= cmd_data[15:0];
          o_surf_q <= cmd_data[31:16];
        end
        WI_W'(5): waddr_q <= cmd_data;
        WI_W'(6): daddr_q <= cmd_data;
        WI_W'(7): raddr_q <= cmd_data;
        default: ;
      endcase
    end
  end

`ifdef CMD_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if ((state_q == S_IDLE) && (state_d == S_FETCH)) begin
      perf_q <= '0;
    end else if ((state_q == S_RUN) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

  assign cmd_ready         = (state_q == S_FETCH);
  assign busy              = (state_q != S_IDLE);
  assign irq               = (state_q == S_DONE) || (state_q == S_ERR);
  assign err               = (state_q == S_ERR);
  assign engine_reset      = !((state_q == S_ISSUE) || (state_q == S_RUN));
  assign eng_start         = eng_start_q;
  assign op_type           = op_type_q;
  assign padding           = padding_q;
  assign stride            = stride_q;
  assign op_num            = op_num_q;
  assign kernel_size       = kernel_q;
  assign i_side_size       = i_side_q;
  assign o_side_size       = o_side_q;
  assign i_surf_size       = i_surf_q;
  assign o_surf_size       = o_surf_q;
  assign i_channel_size    = i_chan_q;
  assign o_channel_size    = o_chan_q;
  assign weight_start_addr = waddr_q;
  assign data_start_addr   = daddr_q;
  assign result_start_addr = raddr_q;

endmodule

// File: tb/tb_cmd_seq_ctrl.sv
// Directed bench for cmd_seq_ctrl with 10-word commands, PARA=16 and three engines.
module tb_cmd_seq_ctrl;
  localparam int CW    = 10;
  localparam int PARA  = 16;
  localparam int NE    = 3;
  localparam int CNT_W = 7;

  typedef struct packed {
    logic [2:0]  op;
    logic        pad;
    logic [3:0]  stride;
    logic [15:0] opn, ichan, ochan;
    logic [7:0]  iside, oside, kern;
    logic [15:0] isurf, osurf;
    logic [31:0] wa, da, ra;
  } cmd_t;

  logic clk = 1'b0;
  logic rst, op_en, cmd_valid, cmd_ready, irq_clr;
  logic [31:0] cmd_data;
  logic [CNT_W-1:0] cmd_size;
  logic [NE-1:0] eng_start, eng_done;
  logic [2:0] op_type;
  logic padding, engine_reset, busy, err, irq;
  logic [3:0] stride;
  logic [15:0] op_num, i_surf_size, o_surf_size, i_channel_size, o_channel_size;
  logic [7:0] kernel_size, i_side_size, o_side_size;
  logic [31:0] weight_start_addr, data_start_addr, result_start_addr, perf_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int b0 = 0;
  cmd_t c;
  logic [31:0] perf_exp;

  cmd_seq_ctrl #(.CMD_WORDS(CW), .PARA(PARA), .NUM_ENG(NE), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .op_en(op_en), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .cmd_size(cmd_size), .eng_start(eng_start), .eng_done(eng_done),
    .op_type(op_type), .padding(padding), .stride(stride), .op_num(op_num),
    .kernel_size(kernel_size), .i_side_size(i_side_size), .o_side_size(o_side_size),
    .i_surf_size(i_surf_size), .o_surf_size(o_surf_size), .i_channel_size(i_channel_size),
    .o_channel_size(o_channel_size), .weight_start_addr(weight_start_addr),
    .data_start_addr(data_start_addr), .result_start_addr(result_start_addr),
    .engine_reset(engine_reset), .busy(busy), .err(err), .irq(irq), .irq_clr(irq_clr),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_valid && cmd_ready) beats++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic [15:0] osurf,
                              input logic [15:0] ochan, input logic [7:0] k);
    cmd_t r;
    r.op = op; r.pad = k[0]; r.stride = k[3:0]; r.opn = {8'hA0, k};
    r.ichan = {8'h01, k}; r.ochan = ochan;
    r.iside = k + 8'd3; r.oside = k + 8'd1; r.kern = k ^ 8'h5A;
    r.isurf = {k, 8'h11}; r.osurf = osurf;
    r.wa = {24'h100000, k}; r.da = {24'h200000, k}; r.ra = {24'h300000, k};
    return r;
  endfunction

  function automatic logic [31:0] wd(input cmd_t x, input int i);
    case (i)
      0: return {x.opn, 4'h0, x.stride, 3'b000, x.pad, 1'b0, x.op};
      1: return 32'hC0FF_EE00;
      2: return {x.ochan, x.ichan};
      3: return {8'hEE, x.kern, x.oside, x.iside};
      4: return {x.osurf, x.isurf};
      5: return x.wa;
      6: return x.da;
      7: return x.ra;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push_word(input logic [31:0] w, input int gap);
    int t = 0;
    cmd_valid = 1'b0;
    repeat (gap) tick();
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (!cmd_ready && t < 40) begin
      tick();
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send(input cmd_t x, input int gap);
    for (int i = 0; i < CW; i++) push_word(wd(x, i), gap);
  endtask

  task automatic start(input logic [CNT_W-1:0] n);
    cmd_size = n;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    b0 = beats;
  endtask

  task automatic pulse(input logic [NE-1:0] m);
    eng_done = m;
    tick();
    eng_done = '0;
  endtask

  task automatic clear();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("clr_irq", irq, 0);
    chk("clr_err", err, 0);
    chk("clr_busy", busy, 0);
  endtask

  task automatic chk_fields(input cmd_t x);
    chk("f_op", op_type, x.op);
    chk("f_pad", padding, x.pad);
    chk("f_stride", stride, x.stride);
    chk("f_opnum", op_num, x.opn);
    chk("f_kern", kernel_size, x.kern);
    chk("f_iside", i_side_size, x.iside);
    chk("f_oside", o_side_size, x.oside);
    chk("f_isurf", i_surf_size, x.isurf);
    chk("f_osurf", o_surf_size, x.osurf);
    chk("f_ichan", i_channel_size, x.ichan);
    chk("f_ochan", o_channel_size, x.ochan);
    chk("f_waddr", weight_start_addr, x.wa);
    chk("f_daddr", data_start_addr, x.da);
    chk("f_raddr", result_start_addr, x.ra);
  endtask

  task automatic err_case(input cmd_t x);
    start(1);
    send(x, 0);
    tick();
    chk("e_err", err, 1);
    chk("e_start", eng_start, 0);
    clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_en = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    cmd_size = '0; eng_done = '0; irq_clr = 1'b0;
    repeat (2) tick();
    chk("rst_start", eng_start, 0);
    chk("rst_ereset", engine_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_op", op_type, 0);
    chk("rst_perf", perf_cycles, 0);
    rst = 1'b0;
    tick();

    // conv: 4 surfaces x 2 channel passes = 8 pulses
    start(1);
    chk("t1_ready", cmd_ready, 1);
    c = mk(3'd2, 16'd4, 16'd32, 8'h21);
    send(c, 0);
    chk("t1_issue_ereset", engine_reset, 0);
    chk("t1_issue_ready", cmd_ready, 0);
    tick();
    chk_fields(c);
    for (int i = 1; i <= 8; i++) begin
      chk("t1_run_start", eng_start, 3'b001);
      chk("t1_run_irq", irq, 0);
      pulse(3'b001);
    end
    chk("t1_irq", irq, 1);
    chk("t1_end_start", eng_start, 0);
    chk("t1_end_ereset", engine_reset, 1);
    chk("t1_ready_low", cmd_ready, 0);
    chk("t1_beats", beats - b0, CW);
    clear();

    // maxpool then avepool with gapped valid
    start(2);
    c = mk(3'd4, 16'd1, 16'd16, 8'h42);
    send(c, 1);
    tick();
    chk("t2a_start", eng_start, 3'b010);
    chk_fields(c);
    pulse(3'b010);
    chk("t2_refetch", cmd_ready, 1);
    chk("t2_mid_irq", irq, 0);
    chk("t2_mid_start", eng_start, 0);
    c = mk(3'd5, 16'd2, 16'd16, 8'h63);
    send(c, 1);
    tick();
    chk("t2b_start", eng_start, 3'b100);
    chk_fields(c);
    pulse(3'b100);
    chk("t2_noirq", irq, 0);
    pulse(3'b100);
    chk("t2_irq", irq, 1);
    chk("t2_beats", beats - b0, 2 * CW);
    clear();

    // op_type 0 in the second of three commands
    start(3);
    send(mk(3'd1, 16'd1, 16'd16, 8'h05), 0);
    tick();
    chk("t3a_start", eng_start, 3'b001);
    pulse(3'b001);
    send(mk(3'd0, 16'd1, 16'd16, 8'h06), 0);
    tick();
    chk("t3_err", err, 1);
    chk("t3_irq", irq, 1);
    chk("t3_start", eng_start, 0);
    chk("t3_busy", busy, 1);
    tick();
    chk("t3_sticky", err, 1);
    clear();
    err_case(mk(3'd6, 16'd1, 16'd16, 8'h07));
    err_case(mk(3'd2, 16'd0, 16'd16, 8'h08));
    err_case(mk(3'd2, 16'd1, 16'd0, 8'h09));

    // o_chan=40 rounds up to 3 passes of 2 surfaces; stray engine-1 pulses, irq_clr, op_en ignored
    start(1);
    c = mk(3'd3, 16'd2, 16'd40, 8'h77);
    send(c, 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      pulse(3'b001);
      irq_clr = (i == 3);
      op_en = (i == 2);
      pulse(3'b010);
      irq_clr = 1'b0;
      op_en = 1'b0;
      chk("t4_run_start", eng_start, 3'b001);
      chk("t4_run_irq", irq, 0);
    end
    pulse(3'b001);
    chk("t4_irq", irq, 1);
`ifdef CMD_SEQ_PERF_CNT_EN
    perf_exp = 32'd11;
`else
    perf_exp = 32'd0;
`endif
    chk("t4_perf", perf_cycles, perf_exp);
    clear();

    // empty program
    start(0);
    chk("t5_irq", irq, 1);
    chk("t5_busy", busy, 1);
    chk("t5_ready", cmd_ready, 0);
    tick();
    chk("t5_ready2", cmd_ready, 0);
    chk("t5_beats", beats - b0, 0);
    clear();

    // reset in the middle of a fetch, then a clean refetch
    start(1);
    c = mk(3'd2, 16'd1, 16'd16, 8'h99);
    for (int i = 0; i < 3; i++) push_word(wd(c, i), 0);
    cmd_valid = 1'b1;
    cmd_data  = wd(c, 3);
    rst = 1'b1;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_ready", cmd_ready, 0);
    chk("t6_op", op_type, 0);
    chk("t6_ereset", engine_reset, 1);
    chk("t6_perf", perf_cycles, 0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();
    start(1);
    c = mk(3'd5, 16'd1, 16'd8, 8'hB4);
    send(c, 0);
    tick();
    chk("t6_start", eng_start, 3'b100);
    chk_fields(c);
    pulse(3'b100);
    chk("t6_irq", irq, 1);
    chk("t6_beats", beats - b0, CW);
`ifdef CMD_SEQ_PERF_CNT_EN
    perf_exp = 32'd1;
`else
    perf_exp = 32'd0;
`endif
    chk("t6_perf_run", perf_cycles, perf_exp);
    clear();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmd_seq_ctrl.md
Name: cmd_seq_ctrl

Overview:
Parametrised command sequencer for the accelerator engines. It fetches fixed-length command bursts over a valid/ready stream, decodes them into operation fields and starts one of NUM_ENG engines. It tracks per-pixel completions across output surfaces and PARA-wide channel groups, then loops until cmd_size commands are done and raises a sticky interrupt. It sits between the command-DMA read port and the conv/maxpool/avepool engines, and generalises the fixed 8-word, 16-lane, three-engine sequencer.

Parameters:
CMD_WORDS, 8, 32-bit words per command (min 8; words beyond 8 are consumed and ignored)
PARA, 16, output channels completed per surface pass
NUM_ENG, 3, engine count; op_type 1..3 -> engine 0, 4 -> engine 1, 5 -> engine 2, 6..7 -> engine 3..4 if present
CNT_W, 7, width of cmd_size and the command counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
op_en  in  1  start pulse/level, sampled in IDLE only
cmd_valid  in  1  command word valid
cmd_data  in  32  command word
cmd_ready  out  1  command word accepted when cmd_valid & cmd_ready
cmd_size  in  CNT_W  number of commands in the program
eng_start  out  NUM_ENG  one-hot, held high while that engine runs
eng_done  in  NUM_ENG  per-engine one-cycle pulse, one output pixel (PARA channels) done
op_type  out  3  decoded op type
padding  out  1  padding flag
stride  out  4  stride
op_num  out  16  op count (center field)
kernel_size  out  8
i_side_size  out  8
o_side_size  out  8
i_surf_size  out  16
o_surf_size  out  16
i_channel_size  out  16
o_channel_size  out  16
weight_start_addr  out  32
data_start_addr  out  32
result_start_addr  out  32
engine_reset  out  1  high except during ISSUE/RUN
busy  out  1  state != IDLE
err  out  1  sticky, illegal op_type or zero-size field
irq  out  1  sticky completion/error interrupt
irq_clr  in  1  clears irq and err, returns to IDLE
perf_cycles  out  32  RUN-state cycle count (optional feature)

Behaviour:
- Reset: all outputs 0 except engine_reset=1; state IDLE; all counters 0.
- States: IDLE, FETCH, ISSUE, RUN, DONE, ERR.
- IDLE: op_en=1 -> FETCH with cmd_cnt=0. If cmd_size==0 -> DONE directly.
- FETCH: cmd_ready=1. word_idx counts accepted beats 0..CMD_WORDS-1.
  - Word field map: w0 op_type[2:0], padding[4], stride[11:8], op_num[31:16]; w1 ignored (corner/side); w2 i_chan[15:0], o_chan[31:16]; w3 i_side[7:0], o_side[15:8], kernel[23:16]; w4 i_surf[15:0], o_surf[31:16]; w5 weight addr; w6 data addr; w7 result addr.
  - cmd_ready drops in the cycle after the last beat; no beat is accepted outside FETCH.
  - Stall is unlimited while cmd_valid=0.
- ISSUE (1 cycle): decode.
  - op_type 0, unmapped engine, o_surf_size==0 or o_channel_size==0 -> ERR.
  - Otherwise set the matching eng_start bit, clear surf_cnt/chan_cnt -> RUN.
- RUN:
  - eng_done of the active engine increments surf_cnt. Pulses from other engines are ignored.
  - When surf_cnt+1==o_surf_size on a done pulse: surf_cnt<=0, chan_cnt<=chan_cnt+PARA. chan_cnt is 17 bits.
  - When chan_cnt+PARA >= o_channel_size at that same pulse, the op is complete. Non-multiple channel counts round up.
  - On completion, in the same cycle: eng_start<=0, engine_reset<=1, cmd_cnt++.
    - Next state is DONE if cmd_cnt+1==cmd_size, else FETCH.
  - Latency: the last eng_done to the next cmd_ready is 1 cycle.
- DONE: irq=1, busy=1. irq_clr -> IDLE with irq=0.
- ERR: err=1, irq=1, all eng_start=0. irq_clr -> IDLE with err=0 and irq=0.
- irq_clr in any other state is ignored. op_en outside IDLE is ignored.
- Reset mid-operation aborts immediately to the reset values; a partially fetched command is discarded.

Optional Feature:
CMD_SEQ_PERF_CNT_EN:
- Defined: perf_cycles counts every RUN cycle across the whole program. It saturates at 2^32-1 and clears on the IDLE->FETCH transition.
- Undefined: perf_cycles tied to 0 and no counter logic is generated.

Test Plan:
1. cmd_size=1, conv cmd (op_type=2, o_surf=4, o_chan=32), 8 eng_done[0] pulses -> eng_start=001 through pulse 8; irq=1 one cycle after pulse 8; op_done count 1.
2. cmd_size=2, maxpool then avepool, cmd_valid gapped every other cycle -> all fields latched correctly; eng_start 010 then 100; irq after second op only.
3. op_type=0 in the second of 3 commands -> err=1 and irq=1 after ISSUE, eng_start=0; irq_clr -> IDLE, err=0.
4. o_chan=40, PARA=16, o_surf=2 -> complete after 6 pulses (3 channel passes); stray eng_done[1] pulses ignored.
5. cmd_size=0 with op_en -> DONE next cycle, irq=1, no cmd_ready; CMD_WORDS=10 run -> 10 beats consumed per command.
6. rst asserted at FETCH word 3 -> all outputs reset next edge; new op_en refetches from word 0; with CMD_SEQ_PERF_CNT_EN, perf_cycles equals the count of RUN cycles.
